// File: rtl/axi_lite_master.sv
// AXI-lite master bridging a simple valid/ready core request port to AXI-lite.
// One transaction is outstanding at a time. All AXI valids/readies are flops,
// and address/data are driven straight from the request capture registers,
// so they stay stable while their valid is high.
module axi_lite_master #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,

    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,

    output logic [AW-1:0] m_axi_awaddr,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [DW-1:0] m_axi_wdata,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,
    output logic [AW-1:0] m_axi_araddr,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [DW-1:0] m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B,
        RESP
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          aw_done;
    logic          w_done;
    logic          unused_resp_lsbs;

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;

    // A write channel counts as finished once its valid has already dropped
    // or its handshake completes on the coming edge.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    // Only the top response bit distinguishes error from success.
    assign unused_resp_lsbs = m_axi_rresp[0] ^ m_axi_bresp[0];

    // Transaction sequencer: all handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            state         <= WR;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end else begin
                            state         <= AR;
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= R;
                    end
                end
                R: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        resp_rdata   <= m_axi_rdata;
                        resp_err     <= m_axi_rresp[1];
                        m_axi_rready <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= B;
                    end
                end
                B: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        resp_err     <= m_axi_bresp[1];
                        m_axi_bready <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: an in-bench AXI-lite slave with configurable
// per-channel latencies, plus a latency/response model computed from the
// transaction rules (address stalls, response delay, error = resp >= 2).
module tb_axi_lite_master;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last_rdata = '0;

    axi_lite_master #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction against the in-bench slave. Reports the observed
    // response, latency (cycles from acceptance to first resp_valid), valid
    // high-cycle counts and a count of protocol violations seen along the way.
    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int aw_lat, input int w_lat, input int ar_lat, input int rsp_lat,
                          input logic [DW-1:0] sd, input logic [1:0] sr, input int hold,
                          output logic [DW-1:0] got_rdata, output logic got_err, output int lat,
                          output int awv_n, output int wv_n, output int perr);
        bit aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0, b_hs = 0;
        bit p_aw = 0, p_w = 0, p_ar = 0, seen = 0, done = 0;
        int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0, held = 0;
        lat = -1; awv_n = 0; wv_n = 0; perr = 0; got_rdata = '0; got_err = 1'b0;
        if (req_ready !== 1'b1) perr++;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        resp_ready = 1'b0;
        step();
        for (int c = 1; c < 200 && !done; c++) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = {$urandom, $urandom};
            if (p_aw && !m_axi_awvalid) perr++;
            if (p_w && !m_axi_wvalid) perr++;
            if (p_ar && !m_axi_arvalid) perr++;
            if (m_axi_awvalid && (aw_hs || m_axi_awaddr !== a)) perr++;
            if (m_axi_wvalid && (w_hs || m_axi_wdata !== d)) perr++;
            if (m_axi_arvalid && (ar_hs || m_axi_araddr !== a)) perr++;
            if (wr && (m_axi_arvalid || m_axi_rready)) perr++;
            if (!wr && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) perr++;
            if (m_axi_bready && (!(aw_hs && w_hs) || b_hs)) perr++;
            if (m_axi_rready && (!ar_hs || r_hs)) perr++;
            if (req_ready !== 1'b0) perr++;
            if (m_axi_awvalid) awv_n++;
            if (m_axi_wvalid) wv_n++;
            if (resp_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; lat = c; got_rdata = resp_rdata; got_err = resp_err;
                end else if (resp_rdata !== got_rdata || resp_err !== got_err) begin
                    perr++;
                end
                if (held < hold) begin
                    held++; resp_ready = 1'b0; req_valid = 1'b1;
                end else begin
                    resp_ready = 1'b1; done = 1;
                end
            end else begin
                if (seen) perr++;
                resp_ready = 1'($urandom);
            end
            // Response channels first, using handshakes completed on past edges.
            if (!wr && ar_hs && !r_hs) begin
                m_axi_rvalid = (r_wait >= rsp_lat);
                r_wait++;
            end else begin
                m_axi_rvalid = 1'b0;
            end
            m_axi_rdata = m_axi_rvalid ? sd : {$urandom, $urandom};
            m_axi_rresp = m_axi_rvalid ? sr : 2'($urandom);
            if (m_axi_rvalid && m_axi_rready) r_hs = 1;
            if (wr && aw_hs && w_hs && !b_hs) begin
                m_axi_bvalid = (b_wait >= rsp_lat);
                b_wait++;
            end else begin
                m_axi_bvalid = 1'b0;
            end
            m_axi_bresp = m_axi_bvalid ? sr : 2'($urandom);
            if (m_axi_bvalid && m_axi_bready) b_hs = 1;
            // Address/data channels: ready after the requested number of stall cycles.
            if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_lat); aw_wait++; end
            else m_axi_awready = 1'($urandom);
            if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_lat); w_wait++; end
            else m_axi_wready = 1'($urandom);
            if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_lat); ar_wait++; end
            else m_axi_arready = 1'($urandom);
            p_aw = m_axi_awvalid && !m_axi_awready;
            p_w  = m_axi_wvalid && !m_axi_wready;
            p_ar = m_axi_arvalid && !m_axi_arready;
            if (m_axi_awvalid && m_axi_awready) aw_hs = 1;
            if (m_axi_wvalid && m_axi_wready) w_hs = 1;
            if (m_axi_arvalid && m_axi_arready) ar_hs = 1;
            step();
        end
        if (!done) begin
            perr += 100;
        end else if (resp_valid !== 1'b0 || req_ready !== 1'b1 || m_axi_awvalid || m_axi_wvalid ||
                     m_axi_arvalid || m_axi_rready || m_axi_bready) begin
            perr++;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset.handshake got req_ready=%b resp_valid=%b resp_err=%b exp 1 0 0",
                     req_ready, resp_valid, resp_err);
        end
        checks++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset.axi_ctrl got=%b exp=00000",
                     {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready});
        end
        checks++;
        if (resp_rdata !== '0 || m_axi_awaddr !== '0 || m_axi_wdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset.data got rdata=%h addr=%h wdata=%h exp all zero",
                     resp_rdata, m_axi_awaddr, m_axi_wdata);
        end
        rst = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset.release got req_ready=%b resp_valid=%b exp 1 0", req_ready, resp_valid);
        end
        last_rdata = '0;
    endtask

    task automatic test_load_basic();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b0, 16'hbff8, '0, 0, 0, 0, 0, 64'h0000_0000_0000_1234, 2'b00, 0, rd, er, lat, awn, wn, pe);
        last_rdata = 64'h1234;
        checks++;
        if (lat !== 3) begin failures++; $display("[TB] FAIL load_basic.latency got=%0d exp=3", lat); end
        checks++;
        if (rd !== 64'h1234) begin failures++; $display("[TB] FAIL load_basic.rdata got=%h exp=%h", rd, 64'h1234); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("[TB] FAIL load_basic.err got=%b exp=0", er); end
        checks++;
        if (pe !== 0) begin failures++; $display("[TB] FAIL load_basic.protocol got=%0d violations exp=0", pe); end
    endtask

    task automatic test_store_basic();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b1, 16'h4000, 64'h100, 0, 0, 0, 0, '0, 2'b00, 0, rd, er, lat, awn, wn, pe);
        checks++;
        if (awn !== 1 || wn !== 1) begin
            failures++; $display("[TB] FAIL store_basic.valid_cycles got aw=%0d w=%0d exp 1 1", awn, wn);
        end
        checks++;
        if (lat !== 3) begin failures++; $display("[TB] FAIL store_basic.latency got=%0d exp=3", lat); end
        checks++;
        if (er !== 1'b0 || rd !== last_rdata) begin
            failures++; $display("[TB] FAIL store_basic.resp got err=%b rdata=%h exp 0 %h", er, rd, last_rdata);
        end
        checks++;
        if (pe !== 0) begin failures++; $display("[TB] FAIL store_basic.protocol got=%0d violations exp=0", pe); end
    endtask

    task automatic test_store_aw_delay();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b1, 16'h1230, 64'hdead_beef_0000_0001, 3, 0, 0, 0, '0, 2'b01, 0, rd, er, lat, awn, wn, pe);
        checks++;
        if (awn !== 4 || wn !== 1) begin
            failures++; $display("[TB] FAIL store_aw_delay.valid_cycles got aw=%0d w=%0d exp 4 1", awn, wn);
        end
        checks++;
        if (lat !== 6) begin failures++; $display("[TB] FAIL store_aw_delay.latency got=%0d exp=6", lat); end
        checks++;
        if (er !== 1'b0 || rd !== last_rdata) begin
            failures++; $display("[TB] FAIL store_aw_delay.resp got err=%b rdata=%h exp 0 %h", er, rd, last_rdata);
        end
        checks++;
        if (pe !== 0) begin failures++; $display("[TB] FAIL store_aw_delay.protocol got=%0d violations exp=0", pe); end
    endtask

    task automatic test_load_err();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b0, 16'h0008, '0, 0, 0, 1, 0, 64'h5555_aaaa_0000_ffff, 2'b10, 0, rd, er, lat, awn, wn, pe);
        last_rdata = 64'h5555_aaaa_0000_ffff;
        checks++;
        if (er !== 1'b1 || rd !== last_rdata || pe !== 0) begin
            failures++; $display("[TB] FAIL load_err.slverr got err=%b rdata=%h viol=%0d exp 1 %h 0", er, rd, pe, last_rdata);
        end
        do_txn(1'b0, 16'h0010, '0, 0, 0, 0, 0, 64'h0123_4567_89ab_cdef, 2'b00, 0, rd, er, lat, awn, wn, pe);
        last_rdata = 64'h0123_4567_89ab_cdef;
        checks++;
        if (er !== 1'b0 || rd !== last_rdata || pe !== 0) begin
            failures++; $display("[TB] FAIL load_err.okay got err=%b rdata=%h viol=%0d exp 0 %h 0", er, rd, pe, last_rdata);
        end
    endtask

    task automatic test_resp_hold();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b0, 16'h7ff0, '0, 0, 0, 0, 0, 64'hcafe_f00d_1111_2222, 2'b11, 5, rd, er, lat, awn, wn, pe);
        last_rdata = 64'hcafe_f00d_1111_2222;
        checks++;
        if (pe !== 0) begin failures++; $display("[TB] FAIL resp_hold.stability got=%0d violations exp=0", pe); end
        checks++;
        if (er !== 1'b1 || rd !== last_rdata || lat !== 3) begin
            failures++; $display("[TB] FAIL resp_hold.resp got err=%b rdata=%h lat=%0d exp 1 %h 3", er, rd, lat, last_rdata);
        end
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            m_axi_rvalid = 1'b1; m_axi_bvalid = 1'b1;
            m_axi_rdata = {$urandom, $urandom}; m_axi_rresp = 2'b10; m_axi_bresp = 2'b11;
            step();
            checks++;
            if (m_axi_rready !== 1'b0 || m_axi_bready !== 1'b0 || resp_valid !== 1'b0 ||
                resp_rdata !== last_rdata) begin
                failures++;
                $display("[TB] FAIL spurious.ignored got rready=%b bready=%b resp_valid=%b rdata=%h exp 0 0 0 %h",
                         m_axi_rready, m_axi_bready, resp_valid, resp_rdata, last_rdata);
            end
        end
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, sd, d, exp_rd; logic er, exp_er; logic [AW-1:0] a; logic [1:0] sr;
        int lat, awn, wn, pe, awl, wl, arl, rl, hold, exp_lat;
        bit wr;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom); a = AW'($urandom); d = {$urandom, $urandom}; sd = {$urandom, $urandom};
            sr = 2'($urandom);
            awl = $urandom_range(0, 3); wl = $urandom_range(0, 3); arl = $urandom_range(0, 3);
            rl = $urandom_range(0, 2); hold = $urandom_range(0, 2);
            do_txn(wr, a, d, awl, wl, arl, rl, sd, sr, hold, rd, er, lat, awn, wn, pe);
            exp_lat = wr ? 3 + ((awl > wl) ? awl : wl) + rl : 3 + arl + rl;
            exp_er  = (sr >= 2'd2);
            exp_rd  = wr ? last_rdata : sd;
            last_rdata = exp_rd;
            checks++;
            if (lat !== exp_lat || rd !== exp_rd || er !== exp_er) begin
                failures++;
                $display("[TB] FAIL random[%0d].resp got lat=%0d rdata=%h err=%b exp %0d %h %b",
                         t, lat, rd, er, exp_lat, exp_rd, exp_er);
            end
            checks++;
            if (pe !== 0 || (wr && (awn !== awl + 1 || wn !== wl + 1))) begin
                failures++;
                $display("[TB] FAIL random[%0d].protocol got viol=%0d aw=%0d w=%0d exp 0 %0d %0d",
                         t, pe, awn, wn, awl + 1, wl + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2468; req_wdata = 64'h77;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (m_axi_awvalid !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_mid.pending got awvalid=%b exp=1", m_axi_awvalid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid.cleared got awvalid=%b wvalid=%b req_ready=%b resp_valid=%b exp 0 0 1 0",
                     m_axi_awvalid, m_axi_wvalid, req_ready, resp_valid);
        end
        checks++;
        if (resp_rdata !== '0 || m_axi_awaddr !== '0) begin
            failures++; $display("[TB] FAIL reset_mid.data got rdata=%h addr=%h exp 0 0", resp_rdata, m_axi_awaddr);
        end
        last_rdata = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0 || m_axi_awvalid !== 1'b0) begin
                failures++; $display("[TB] FAIL reset_mid.no_resp got resp_valid=%b awvalid=%b exp 0 0",
                                     resp_valid, m_axi_awvalid);
            end
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    endtask

    task automatic test_after_reset();
        logic [DW-1:0] rd; logic er; int lat, awn, wn, pe;
        do_txn(1'b1, 16'h0100, 64'h9, 1, 2, 0, 1, '0, 2'b10, 1, rd, er, lat, awn, wn, pe);
        checks++;
        if (rd !== '0 || er !== 1'b1 || lat !== 6 || pe !== 0) begin
            failures++; $display("[TB] FAIL after_reset.store got rdata=%h err=%b lat=%0d viol=%0d exp 0 1 6 0",
                                 rd, er, lat, pe);
        end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
        #1;
        test_reset();
        test_load_basic();
        test_store_basic();
        test_store_aw_delay();
        test_load_err();
        test_resp_hold();
        test_spurious();
        test_random();
        test_reset_mid();
        test_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter AW, default 16, address width of request and AXI address channels.
REQ-002 Parameter DW, default 64, data width of request, response and AXI data channels.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  block idle and accepting a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  AW  request byte address.
REQ-009 req_wdata  input  DW  store data.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  core accepts response.
REQ-012 resp_rdata  output  DW  load data; holds last value after a store.
REQ-013 resp_err  output  1  AXI response was SLVERR or DECERR.
REQ-014 m_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp[1:0]/bvalid/bready, araddr/arvalid/arready, rdata/rresp[1:0]/rvalid/rready: AXI-lite master ports; widths AW/DW; directions mirror an AXI-lite slave.

Function
REQ-015 FSM states: IDLE, AR, R, WR, B, RESP.
REQ-016 req_ready is 1 only in IDLE; request accepted when req_valid & req_ready; addr/wdata/write latched that cycle.
REQ-017 IDLE -> AR on accepted load; IDLE -> WR on accepted store; outputs registered, so arvalid or awvalid+wvalid rise exactly 1 cycle after acceptance.
REQ-018 AR: arvalid=1, araddr=latched addr; on arvalid & arready -> R, arvalid=0 next cycle.
REQ-019 R: rready=1; on rvalid & rready capture rdata into resp_rdata, resp_err=rresp[1] -> RESP.
REQ-020 WR: awvalid and wvalid asserted together; each drops independently the cycle after its own handshake; awaddr/wdata stable while respective valid is high.
REQ-021 WR -> B once both AW and W handshakes have completed, including both in the same cycle or in different cycles in either order.
REQ-022 bready=0 outside B; B: bready=1; on bvalid & bready resp_err=bresp[1], resp_rdata unchanged -> RESP.
REQ-023 RESP: resp_valid=1, held with stable resp_rdata/resp_err until resp_ready; on handshake -> IDLE, resp_valid=0 next cycle.
REQ-024 Best-case latency with always-ready slave responding 1 cycle after address handshake: acceptance at cycle N -> resp_valid at N+3.
REQ-025 Exactly one transaction outstanding; no new request accepted until RESP handshake completes.
REQ-026 A valid, once raised, is never withdrawn before its handshake except by rst.
REQ-027 rvalid/bvalid seen outside R/B are ignored (ready low).
REQ-028 resp_err is 0 for OKAY (00) and EXOKAY (01), 1 for SLVERR (10) and DECERR (11).

Reset
REQ-029 On rst: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, arvalid=awvalid=wvalid=0, rready=bready=0, latched addr/data=0.
REQ-030 rst asserted mid-transaction discards the transaction; all valids low on the cycle after rst, no response produced.

Verification
REQ-031 Load addr 16'hbff8, slave arready=1, rdata=64'h0000_0000_0000_1234 rresp=00 one cycle later -> resp_valid at N+3, resp_rdata=64'h1234, resp_err=0.
REQ-032 Store addr 16'h4000 data 64'h100, slave awready=wready=1, bvalid next cycle bresp=00 -> awvalid/wvalid high exactly 1 cycle, resp_valid at N+3, resp_err=0, resp_rdata unchanged.
REQ-033 Store with awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready only after both handshakes.
REQ-034 Load with rresp=2'b10 -> resp_err=1; next load with rresp=00 -> resp_err=0.
REQ-035 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, new req_valid ignored until handshake.
REQ-036 rst pulse while awvalid=1 and awready=0 -> cycle after: awvalid=wvalid=0, req_ready=1, resp_valid=0.
